// File: rtl/sprite_pkg.sv
// Shared types and screen/blitter limits for the sprite draw sequencer.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned MAX_AREA = 4095;
  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned AREA_W   = 20;

  typedef struct packed {
    logic [ADDR_W-1:0]  rom_addr;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } draw_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } seq_state_t;

  // True when the blitter can draw the command: on-screen origin, non-empty, area fits its counter.
  function automatic logic cmd_is_drawable(draw_cmd_t c);
    logic [AREA_W-1:0] area;
    area = AREA_W'(c.w) * AREA_W'(c.h);
    return (c.w != '0) && (c.h != '0) &&
           (c.x < COORD_W'(SCREEN_W)) && (c.y < COORD_W'(SCREEN_H)) &&
           (area <= AREA_W'(MAX_AREA));
  endfunction

endpackage

// File: rtl/draw_cmd_fifo.sv
// Draw-command FIFO with a registered read port: pop_data is valid the cycle after pop.
module draw_cmd_fifo
  import sprite_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  draw_cmd_t                push_data,
  input  logic                     pop,
  output draw_cmd_t                pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  draw_cmd_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pop_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) begin
        pop_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Replays a per-frame snapshot of queued sprite commands to the blitter, one handshake at a time.
module sprite_draw_sequencer
  import sprite_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_rom_addr,
  input  logic [COORD_W-1:0]  cmd_x,
  input  logic [COORD_W-1:0]  cmd_y,
  input  logic [COORD_W-1:0]  cmd_w,
  input  logic [COORD_W-1:0]  cmd_h,
  input  logic                frame_start,
  output logic                frame_busy,
  output logic                frame_done,
  output logic                overrun,
  output logic [7:0]          drop_count,
  output logic                begin_drawing,
  output logic [ADDR_W-1:0]   start_rom_addr,
  output logic [COORD_W-1:0]  start_x,
  output logic [COORD_W-1:0]  start_y,
  output logic [COORD_W-1:0]  width,
  output logic [COORD_W-1:0]  height,
  input  logic                done_drawing
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  seq_state_t       state, state_d;
  logic [CNT_W-1:0] remaining, remaining_d;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty, fifo_pop;
  draw_cmd_t        fifo_head, push_cmd;
  draw_cmd_t        out_cmd, out_cmd_d;
  logic             frame_start_q;
  logic             overrun_d, frame_busy_d, frame_done_d, begin_drawing_d;
  logic [7:0]       drop_count_d;

  assign push_cmd = '{rom_addr: cmd_rom_addr, x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h};

  draw_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_ready      = !fifo_full;
  assign start_rom_addr = out_cmd.rom_addr;
  assign start_x        = out_cmd.x;
  assign start_y        = out_cmd.y;
  assign width          = out_cmd.w;
  assign height         = out_cmd.h;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state;
    remaining_d  = remaining;
    out_cmd_d    = out_cmd;
    overrun_d    = overrun;
    drop_count_d = drop_count;
    fifo_pop     = 1'b0;

    if (frame_start_q && state != S_IDLE) overrun_d = 1'b1;

    case (state)
      S_IDLE: begin
        if (frame_start_q) begin
          remaining_d = fifo_count;
          state_d     = (fifo_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        fifo_pop = !fifo_empty;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (cmd_is_drawable(fifo_head)) begin
          out_cmd_d = fifo_head;
          state_d   = S_ISSUE;
        end else begin
          if (drop_count != 8'hFF) drop_count_d = drop_count + 8'd1;
          remaining_d = remaining - CNT_W'(1);
          state_d     = (remaining > CNT_W'(1)) ? S_FETCH : S_DONE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (done_drawing) begin
          remaining_d = remaining - CNT_W'(1);
          state_d     = (remaining > CNT_W'(1)) ? S_FETCH : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    begin_drawing_d = (state_d == S_ISSUE);
    frame_done_d    = (state_d == S_DONE);
    frame_busy_d    = (state_d == S_FETCH) || (state_d == S_CHECK) ||
                      (state_d == S_ISSUE) || (state_d == S_WAIT);
  end

  // The vblank pulse is registered before the FSM sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      remaining     <= '0;
      out_cmd       <= '0;
      frame_start_q <= 1'b0;
      overrun       <= 1'b0;
      drop_count    <= '0;
      begin_drawing <= 1'b0;
      frame_done    <= 1'b0;
      frame_busy    <= 1'b0;
    end else begin
      state         <= state_d;
      remaining     <= remaining_d;
      out_cmd       <= out_cmd_d;
      frame_start_q <= frame_start;
      overrun       <= overrun_d;
      drop_count    <= drop_count_d;
      begin_drawing <= begin_drawing_d;
      frame_done    <= frame_done_d;
      frame_busy    <= frame_busy_d;
    end
  end

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Self-checking bench for sprite_draw_sequencer: command tables, blitter model and scoreboard.
module tb_sprite_draw_sequencer;
  import sprite_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [11:0] cmd_rom_addr = '0;
  logic [9:0]  cmd_x = '0, cmd_y = '0, cmd_w = '0, cmd_h = '0;
  logic        frame_start = 1'b0;
  logic        frame_busy, frame_done, overrun, begin_drawing;
  logic [7:0]  drop_count;
  logic [11:0] start_rom_addr;
  logic [9:0]  start_x, start_y, width, height;
  logic        done_drawing = 1'b0;

  sprite_draw_sequencer #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rom_addr(cmd_rom_addr),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .frame_start(frame_start), .frame_busy(frame_busy), .frame_done(frame_done),
    .overrun(overrun), .drop_count(drop_count), .begin_drawing(begin_drawing),
    .start_rom_addr(start_rom_addr), .start_x(start_x), .start_y(start_y),
    .width(width), .height(height), .done_drawing(done_drawing)
  );

  always #5 clk = ~clk;

  typedef struct {
    draw_cmd_t cmd;
    bit        drawable;
  } vec_t;

  int        tests = 0;
  int        fails = 0;
  int        cyc = 0;
  int        blit_delay = 10;
  bit        blit_hold = 1'b0;
  int        bl_cnt = 0;
  draw_cmd_t sb[$];
  int        begin_cyc[$];
  int        done_cyc[$];
  int        fd_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic draw_cmd_t mk(input logic [11:0] a, input logic [9:0] x, input logic [9:0] y,
                                   input logic [9:0] w, input logic [9:0] h);
    return '{rom_addr: a, x: x, y: y, w: w, h: h};
  endfunction

  // Cycle counter, blitter model, begin_drawing scoreboard and event logs.
  always @(posedge clk) begin
    draw_cmd_t got, exp;
    cyc++;
    #1;
    done_drawing = 1'b0;
    if (reset) begin
      bl_cnt = 0;
    end else begin
      if (bl_cnt > 0) begin
        bl_cnt--;
        if (bl_cnt == 0 && !blit_hold) begin
          done_drawing = 1'b1;
          done_cyc.push_back(cyc);
        end
      end
      if (frame_done) fd_cyc.push_back(cyc);
      if (begin_drawing) begin
        begin_cyc.push_back(cyc);
        bl_cnt = blit_delay;
        got = '{rom_addr: start_rom_addr, x: start_x, y: start_y, w: width, h: height};
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_begin: got %0h expected none", got);
        end else begin
          exp = sb.pop_front();
          check("begin_fields", 64'(got), 64'(exp));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    begin_cyc.delete();
    done_cyc.delete();
    fd_cyc.delete();
  endtask

  task automatic push_cmd(input draw_cmd_t c, input bit drawable);
    int n = 0;
    {cmd_rom_addr, cmd_x, cmd_y, cmd_w, cmd_h} = c;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!cmd_ready) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got cmd_ready=0 expected 1");
    end else begin
      tick();
      if (drawable) sb.push_back(c);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_frame(output int fs);
    fs = cyc;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_frame_done(input int bound);
    int n = 0;
    while (fd_cyc.size() == 0 && n < bound) begin
      tick();
      n++;
    end
    if (fd_cyc.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL frame_done_timeout: got no frame_done expected one within %0d cycles", bound);
    end
  endtask

  task automatic wait_begin(input int bound);
    int n = 0;
    while (begin_cyc.size() == 0 && n < bound) begin
      tick();
      n++;
    end
    if (begin_cyc.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL begin_timeout: got no begin_drawing expected one within %0d cycles", bound);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t3[4];
    vec_t tb_bnd[10];
    int   fs, fs2, d0, nvalid;
    draw_cmd_t held;

    t3[0] = '{cmd: mk(12'h001, 10'd0,   10'd0,  10'd0,   10'd5),  drawable: 1'b0};
    t3[1] = '{cmd: mk(12'h002, 10'd700, 10'd0,  10'd4,   10'd4),  drawable: 1'b0};
    t3[2] = '{cmd: mk(12'h003, 10'd10,  10'd10, 10'd100, 10'd50), drawable: 1'b0};
    t3[3] = '{cmd: mk(12'h123, 10'd20,  10'd30, 10'd8,   10'd8),  drawable: 1'b1};

    tb_bnd[0] = '{cmd: mk(12'h010, 10'd639,  10'd0,   10'd1,    10'd1),    drawable: 1'b1};
    tb_bnd[1] = '{cmd: mk(12'h011, 10'd640,  10'd0,   10'd1,    10'd1),    drawable: 1'b0};
    tb_bnd[2] = '{cmd: mk(12'h012, 10'd0,    10'd479, 10'd1,    10'd1),    drawable: 1'b1};
    tb_bnd[3] = '{cmd: mk(12'h013, 10'd0,    10'd480, 10'd1,    10'd1),    drawable: 1'b0};
    tb_bnd[4] = '{cmd: mk(12'h014, 10'd0,    10'd0,   10'd63,   10'd65),   drawable: 1'b1};
    tb_bnd[5] = '{cmd: mk(12'h015, 10'd0,    10'd0,   10'd64,   10'd64),   drawable: 1'b0};
    tb_bnd[6] = '{cmd: mk(12'h016, 10'd5,    10'd5,   10'd5,    10'd0),    drawable: 1'b0};
    tb_bnd[7] = '{cmd: mk(12'h017, 10'd0,    10'd0,   10'd1023, 10'd1),    drawable: 1'b1};
    tb_bnd[8] = '{cmd: mk(12'h018, 10'd0,    10'd0,   10'd1023, 10'd1023), drawable: 1'b0};
    tb_bnd[9] = '{cmd: mk(12'h019, 10'd1023, 10'd0,   10'd2,    10'd2),    drawable: 1'b0};

    // Reset state
    tick();
    check("reset_ctrl", 64'({begin_drawing, frame_busy, frame_done, overrun, drop_count, cmd_ready}),
          64'({1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1}));
    check("reset_fields", 64'({start_rom_addr, start_x, start_y, width, height}), 64'd0);
    reset = 1'b0;
    tick();

    // 1: three valid commands, latency and frame_done ordering
    clear_logs();
    blit_delay = 10;
    push_cmd(mk(12'h100, 10'd10,  10'd20,  10'd16, 10'd16), 1'b1);
    push_cmd(mk(12'h200, 10'd100, 10'd50,  10'd32, 10'd8),  1'b1);
    push_cmd(mk(12'h300, 10'd600, 10'd400, 10'd40, 10'd40), 1'b1);
    pulse_frame(fs);
    tick();
    check("t1_busy", 64'(frame_busy), 64'd1);
    wait_frame_done(300);
    repeat (5) tick();
    check("t1_begins", 64'(begin_cyc.size()), 64'd3);
    check("t1_frame_done_cnt", 64'(fd_cyc.size()), 64'd1);
    if (begin_cyc.size() > 0) check("t1_first_latency", 64'(begin_cyc[0] - fs), 64'd4);
    if (begin_cyc.size() > 1 && done_cyc.size() > 0)
      check("t1_done_to_begin", 64'(begin_cyc[1] - done_cyc[0]), 64'd3);
    if (fd_cyc.size() > 0 && done_cyc.size() > 2)
      check("t1_done_after_last", 64'(fd_cyc[0] > done_cyc[2]), 64'd1);
    check("t1_busy_after", 64'(frame_busy), 64'd0);

    // 2: empty queue
    clear_logs();
    pulse_frame(fs);
    wait_frame_done(20);
    repeat (3) tick();
    if (fd_cyc.size() > 0) check("t2_done_latency", 64'(fd_cyc[0] - fs), 64'd2);
    check("t2_begins", 64'(begin_cyc.size()), 64'd0);
    check("t2_frame_done_cnt", 64'(fd_cyc.size()), 64'd1);

    // 3: three invalid + one valid
    clear_logs();
    for (int i = 0; i < 4; i++) push_cmd(t3[i].cmd, t3[i].drawable);
    pulse_frame(fs);
    wait_frame_done(300);
    repeat (3) tick();
    check("t3_begins", 64'(begin_cyc.size()), 64'd1);
    check("t3_drop_count", 64'(drop_count), 64'd3);
    check("t3_frame_done_cnt", 64'(fd_cyc.size()), 64'd1);

    // Validity boundaries
    clear_logs();
    blit_delay = 3;
    d0 = int'(drop_count);
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      push_cmd(tb_bnd[i].cmd, tb_bnd[i].drawable);
      if (tb_bnd[i].drawable) nvalid++;
    end
    pulse_frame(fs);
    wait_frame_done(500);
    repeat (3) tick();
    check("bnd_begins", 64'(begin_cyc.size()), 64'(nvalid));
    check("bnd_drops", 64'(int'(drop_count) - d0), 64'(10 - nvalid));

    // 4: full queue, held 17th push accepted after first pop but drawn next frame
    clear_logs();
    blit_delay = 2;
    for (int i = 0; i < 16; i++)
      push_cmd(mk(12'(i + 32), 10'(i), 10'(i), 10'd2, 10'd2), 1'b1);
    check("t4_full_ready", 64'(cmd_ready), 64'd0);
    held = mk(12'hABC, 10'd1, 10'd2, 10'd3, 10'd4);
    {cmd_rom_addr, cmd_x, cmd_y, cmd_w, cmd_h} = held;
    cmd_valid = 1'b1;
    pulse_frame(fs);
    check("t4_ready_snapshot", 64'(cmd_ready), 64'd0);
    tick();
    check("t4_ready_pop_cycle", 64'(cmd_ready), 64'd0);
    tick();
    check("t4_ready_after_pop", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    sb.push_back(held);
    wait_frame_done(2000);
    repeat (3) tick();
    check("t4_batch_begins", 64'(begin_cyc.size()), 64'd16);
    clear_logs();
    pulse_frame(fs);
    wait_frame_done(200);
    repeat (3) tick();
    check("t4_next_begins", 64'(begin_cyc.size()), 64'd1);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);

    // 5a: frame_start during WAIT sets overrun without disturbing the batch
    check("t5_overrun_clear", 64'(overrun), 64'd0);
    clear_logs();
    blit_delay = 10;
    push_cmd(mk(12'h555, 10'd50, 10'd60, 10'd10, 10'd10), 1'b1);
    push_cmd(mk(12'h666, 10'd70, 10'd80, 10'd12, 10'd12), 1'b1);
    pulse_frame(fs);
    wait_begin(20);
    repeat (2) tick();
    pulse_frame(fs2);
    tick();
    check("t5_overrun_set", 64'(overrun), 64'd1);
    wait_frame_done(300);
    repeat (10) tick();
    check("t5_begins", 64'(begin_cyc.size()), 64'd2);
    check("t5_frame_done_cnt", 64'(fd_cyc.size()), 64'd1);

    // 5b: reset while waiting on the blitter
    clear_logs();
    blit_hold = 1'b1;
    push_cmd(mk(12'h777, 10'd1, 10'd1, 10'd5, 10'd5), 1'b1);
    push_cmd(mk(12'h888, 10'd2, 10'd2, 10'd6, 10'd6), 1'b1);
    pulse_frame(fs);
    wait_begin(20);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("t5_reset_ctrl",
          64'({begin_drawing, frame_busy, frame_done, overrun, drop_count, cmd_ready}),
          64'({1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1}));
    check("t5_reset_fields", 64'({start_rom_addr, start_x, start_y, width, height}), 64'd0);
    reset = 1'b0;
    sb.delete();
    blit_hold = 1'b0;
    clear_logs();
    repeat (20) tick();
    check("t5_no_frame_done", 64'(fd_cyc.size()), 64'd0);
    clear_logs();
    pulse_frame(fs);
    wait_frame_done(20);
    repeat (3) tick();
    if (fd_cyc.size() > 0) check("t5_empty_latency", 64'(fd_cyc[0] - fs), 64'd2);
    check("t5_queue_empty", 64'(begin_cyc.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
